bounce_generator: RTL

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

---
 rtl/bounce_gen_pkg.sv | 22 ++
 rtl/bounce_generator_lfsr.sv | 29 ++
 rtl/bounce_generator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCING,
        ST_SETTLE
    } state_e;

    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Right-shifting Galois step; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bounce_generator_lfsr.sv
// Free-running 16-bit Galois LFSR, reseeded by asynchronous reset.
module lfsr
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [15:0] o_value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value = lfsr_q;

endmodule

// File: rtl/bounce_generator.sv
// Emulates a bouncing mechanical contact: each clean edge becomes 2N random-length
// glitches followed by a stable settle period.
module bounce_generator
    import bounce_gen_pkg::*;
#(
    parameter int unsigned  COUNTER_WIDTH      = 16,
    parameter int unsigned  BOUNCE_COUNT_WIDTH = 4,
    parameter logic [15:0]  LFSR_SEED          = 16'hACE1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_clean_signal,
    input  logic [BOUNCE_COUNT_WIDTH-1:0] i_bounce_count,
    input  logic [COUNTER_WIDTH-1:0]      i_bounce_mask,
    input  logic [COUNTER_WIDTH-1:0]      i_settle_cycles,
    output logic                          o_bouncing_signal,
    output logic                          o_busy
);

    logic [15:0]              lfsr_value;
    logic [COUNTER_WIDTH-1:0] lfsr_ext;

    lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_value (lfsr_value)
    );

    generate
        if (COUNTER_WIDTH > 16) begin : g_extend
            assign lfsr_ext = {{(COUNTER_WIDTH-16){1'b0}}, lfsr_value};
        end else begin : g_truncate
            assign lfsr_ext = lfsr_value[COUNTER_WIDTH-1:0];
        end
    endgenerate

    state_e                      state_q,    state_d;
    logic                        out_q,      out_d;
    logic                        busy_q,     busy_d;
    logic [BOUNCE_COUNT_WIDTH:0] toggles_q,  toggles_d;
    logic [COUNTER_WIDTH-1:0]    interval_q, interval_d;
    logic [COUNTER_WIDTH-1:0]    settle_cnt_q, settle_cnt_d;
    logic [COUNTER_WIDTH-1:0]    mask_q,     mask_d;
    logic [COUNTER_WIDTH-1:0]    settle_q,   settle_d;

    always_comb begin
        state_d      = state_q;
        out_d        = out_q;
        toggles_d    = toggles_q;
        interval_d   = interval_q;
        settle_cnt_d = settle_cnt_q;
        mask_d       = mask_q;
        settle_d     = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clean_signal != out_q) begin
                    out_d    = i_clean_signal;
                    mask_d   = i_bounce_mask;
                    settle_d = i_settle_cycles;
                    if (i_bounce_count != '0) begin
                        toggles_d  = {i_bounce_count, 1'b0};
                        interval_d = lfsr_ext & i_bounce_mask;
                        state_d    = ST_BOUNCING;
                    end else begin
                        settle_cnt_d = i_settle_cycles;
                        state_d      = ST_SETTLE;
                    end
                end
            end
            ST_BOUNCING: begin
                if (interval_q != '0) begin
                    interval_d = interval_q - 1'b1;
                end else if (toggles_q != '0) begin
                    out_d      = ~out_q;
                    toggles_d  = toggles_q - 1'b1;
                    interval_d = lfsr_ext & mask_q;
                    // Even toggle count means this last toggle lands on the target level.
                    if (toggles_q == 1) begin
                        interval_d   = '0;
                        settle_cnt_d = settle_q;
                        state_d      = ST_SETTLE;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            out_q        <= 1'b0;
            busy_q       <= 1'b0;
            toggles_q    <= '0;
            interval_q   <= '0;
            settle_cnt_q <= '0;
            mask_q       <= '0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_q        <= out_d;
            busy_q       <= busy_d;
            toggles_q    <= toggles_d;
            interval_q   <= interval_d;
            settle_cnt_q <= settle_cnt_d;
            mask_q       <= mask_d;
            settle_q     <= settle_d;
        end
    end

    assign o_bouncing_signal = out_q;
    assign o_busy            = busy_q;

endmodule
